// File: rtl/relay_drv_pkg.sv
// ============================================================================
// Module   : relay_drv_pkg
// Purpose  : Shared state and command encodings for the relay drive sequencer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package relay_drv_pkg;

  localparam int NUM_CH = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_REV  = 2'd2,
    ST_DEAD = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    CMD_STOP = 2'd0,
    CMD_FWD  = 2'd1,
    CMD_REV  = 2'd2,
    CMD_ILL  = 2'd3
  } cmd_t;

  function automatic cmd_t decode_cmd(input logic i_fwd, input logic i_rev);
    cmd_t v;
    case ({i_fwd, i_rev})
      2'b10:   v = CMD_FWD;
      2'b01:   v = CMD_REV;
      2'b11:   v = CMD_ILL;
      default: v = CMD_STOP;
    endcase
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/relay_channel.sv
// ============================================================================
// Module   : relay_channel
// Purpose  : One motor channel: command register, break-before-make FSM with
//            minimum on-time, dead-time counter and sticky illegal-command flag.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module relay_channel
  import relay_drv_pkg::*;
#(
  parameter int DEAD_CYCLES   = 1000,
  parameter int MIN_ON_CYCLES = 5000,
  parameter int CNT_W         = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_fwd,
  input  logic i_rev,
  input  logic i_fault_clr,
  output logic o_fwd_act,
  output logic o_rev_act,
  output logic o_dead,
  output logic o_fault
);

  localparam logic [CNT_W-1:0] c_DEAD_LAST   = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_MIN_ON_LAST = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] c_ONE         = CNT_W'(1);

  cmd_t             r_cmd;
  state_t           r_state;
  logic [CNT_W-1:0] r_on_cnt;
  logic [CNT_W-1:0] r_dead_cnt;
  logic             r_fwd_act;
  logic             r_rev_act;
  logic             r_dead;
  logic             r_fault;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd      <= CMD_STOP;
      r_state    <= ST_IDLE;
      r_on_cnt   <= '0;
      r_dead_cnt <= '0;
      r_fwd_act  <= 1'b0;
      r_rev_act  <= 1'b0;
      r_dead     <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_cmd <= decode_cmd(i_fwd, i_rev);

      // Setting on an illegal command takes priority over a clear in the same cycle.
      if (r_cmd == CMD_ILL) begin
        r_fault <= 1'b1;
      end else if (i_fault_clr) begin
        r_fault <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          r_on_cnt   <= '0;
          r_dead_cnt <= '0;
          if (r_cmd == CMD_FWD) begin
            r_state   <= ST_FWD;
            r_fwd_act <= 1'b1;
          end else if (r_cmd == CMD_REV) begin
            r_state   <= ST_REV;
            r_rev_act <= 1'b1;
          end
        end

        ST_FWD: begin
          if ((r_cmd == CMD_STOP) || (r_cmd == CMD_ILL) ||
              ((r_cmd == CMD_REV) && (r_on_cnt >= c_MIN_ON_LAST))) begin
            r_state    <= ST_DEAD;
            r_fwd_act  <= 1'b0;
            r_dead     <= 1'b1;
            r_dead_cnt <= '0;
          end else if (r_on_cnt != c_CNT_MAX) begin
            r_on_cnt <= r_on_cnt + c_ONE;
          end
        end

        ST_REV: begin
          if ((r_cmd == CMD_STOP) || (r_cmd == CMD_ILL) ||
              ((r_cmd == CMD_FWD) && (r_on_cnt >= c_MIN_ON_LAST))) begin
            r_state    <= ST_DEAD;
            r_rev_act  <= 1'b0;
            r_dead     <= 1'b1;
            r_dead_cnt <= '0;
          end else if (r_on_cnt != c_CNT_MAX) begin
            r_on_cnt <= r_on_cnt + c_ONE;
          end
        end

        ST_DEAD: begin
          // Dead time always runs to completion; only the exit target follows the command.
          if (r_dead_cnt == c_DEAD_LAST) begin
            r_dead     <= 1'b0;
            r_dead_cnt <= '0;
            r_on_cnt   <= '0;
            if (r_cmd == CMD_FWD) begin
              r_state   <= ST_FWD;
              r_fwd_act <= 1'b1;
            end else if (r_cmd == CMD_REV) begin
              r_state   <= ST_REV;
              r_rev_act <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
            end
          end else begin
            r_dead_cnt <= r_dead_cnt + c_ONE;
          end
        end

        default: begin
          r_state   <= ST_IDLE;
          r_fwd_act <= 1'b0;
          r_rev_act <= 1'b0;
          r_dead    <= 1'b0;
        end
      endcase
    end
  end

  assign o_fwd_act = r_fwd_act;
  assign o_rev_act = r_rev_act;
  assign o_dead    = r_dead;
  assign o_fault   = r_fault;

endmodule

`default_nettype wire

// File: rtl/relay_drive_sequencer.sv
// ============================================================================
// Module   : relay_drive_sequencer
// Purpose  : Two independent relay channels with enable gating. Define
//            MOTOR_PWM_EN to add a shared PWM counter and the duty input.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module relay_drive_sequencer
  import relay_drv_pkg::*;
#(
  parameter int DEAD_CYCLES   = 1000,
  parameter int MIN_ON_CYCLES = 5000,
  parameter int CNT_W         = 16,
  parameter int PWM_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             min11,
  input  logic             min21,
  input  logic             min12,
  input  logic             min22,
  input  logic             fault_clr,
`ifdef MOTOR_PWM_EN
  input  logic [PWM_W-1:0] duty,
`endif
  output logic             rly11,
  output logic             rly21,
  output logic             rly12,
  output logic             rly22,
  output logic [1:0]       dead,
  output logic [1:0]       fault
);

  logic [NUM_CH-1:0] w_fwd_cmd;
  logic [NUM_CH-1:0] w_rev_cmd;
  logic [NUM_CH-1:0] w_fwd_act;
  logic [NUM_CH-1:0] w_rev_act;
  logic              w_pwm_on;

  // Disable presents STOP to both channels so they still pass through dead time.
  assign w_fwd_cmd = {min12, min11} & {NUM_CH{enable}};
  assign w_rev_cmd = {min22, min21} & {NUM_CH{enable}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    relay_channel #(
      .DEAD_CYCLES  (DEAD_CYCLES),
      .MIN_ON_CYCLES(MIN_ON_CYCLES),
      .CNT_W        (CNT_W)
    ) u_channel (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_fwd      (w_fwd_cmd[g]),
      .i_rev      (w_rev_cmd[g]),
      .i_fault_clr(fault_clr),
      .o_fwd_act  (w_fwd_act[g]),
      .o_rev_act  (w_rev_act[g]),
      .o_dead     (dead[g]),
      .o_fault    (fault[g])
    );
  end

`ifdef MOTOR_PWM_EN
  logic [PWM_W-1:0] r_pwm_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
    end
  end

  assign w_pwm_on = (r_pwm_cnt < duty);
`else
  assign w_pwm_on = (PWM_W > 0);
`endif

  assign rly11 = w_fwd_act[0] & w_pwm_on;
  assign rly21 = w_rev_act[0] & w_pwm_on;
  assign rly12 = w_fwd_act[1] & w_pwm_on;
  assign rly22 = w_rev_act[1] & w_pwm_on;

endmodule

`default_nettype wire

// File: tb/tb_relay_drive_sequencer.sv
// ============================================================================
// Module   : tb_relay_drive_sequencer
// Purpose  : Directed self-checking bench, DEAD_CYCLES=4, MIN_ON_CYCLES=8.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_relay_drive_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic       min11, min21, min12, min22;
  logic       fault_clr;
`ifdef MOTOR_PWM_EN
  logic [7:0] duty;
`endif
  logic       rly11, rly21, rly12, rly22;
  logic [1:0] dead;
  logic [1:0] fault;
  logic [3:0] rly;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rly = {rly22, rly12, rly21, rly11};

  relay_drive_sequencer #(
    .DEAD_CYCLES  (4),
    .MIN_ON_CYCLES(8),
    .CNT_W        (16),
    .PWM_W        (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .min11    (min11),
    .min21    (min21),
    .min12    (min12),
    .min22    (min22),
    .fault_clr(fault_clr),
`ifdef MOTOR_PWM_EN
    .duty     (duty),
`endif
    .rly11    (rly11),
    .rly21    (rly21),
    .rly12    (rly12),
    .rly22    (rly22),
    .dead     (dead),
    .fault    (fault)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      assert (!(rly11 && rly21) && !(rly12 && rly22)) else begin
        errors++;
        $error("FAIL relay_overlap: observed=%b expected=no fwd+rev pair", rly);
      end
    end
  end

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    min11     = 1'b0;
    min21     = 1'b0;
    min12     = 1'b0;
    min22     = 1'b0;
    fault_clr = 1'b0;
`ifdef MOTOR_PWM_EN
    duty      = 8'd255;
`endif
    tick(2);
    check("reset_rly", 9'(rly), 9'h0);
    check("reset_dead", 9'(dead), 9'h0);
    check("reset_fault", 9'(fault), 9'h0);
    rst_n = 1'b1;
    tick(1);

    // Forward from idle: two edges of latency.
    min11 = 1'b1;
    tick(1);
    check("fwd_lat1", 9'(rly), 9'h0);
    tick(1);
    check("fwd_on", 9'(rly), 9'b0001);
    check("fwd_dead", 9'(dead), 9'h0);

    // Reversal after 3 FWD cycles waits for min-on, then 4 dead cycles.
    tick(2);
    min11 = 1'b0;
    min21 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("minon_hold", 9'(rly), 9'b0001);
    end
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("rev_dead_rly", 9'(rly), 9'h0);
      check("rev_dead_flag", 9'(dead), 9'b01);
    end
    tick(1);
    check("rev_on", 9'(rly), 9'b0010);
    check("rev_on_dead", 9'(dead), 9'h0);

    min21 = 1'b0;
    tick(6);
    check("stop_idle_rly", 9'(rly), 9'h0);
    check("stop_idle_dead", 9'(dead), 9'h0);

    // STOP at on_cnt=2: no min-on wait.
    min11 = 1'b1;
    tick(2);
    check("s3_fwd", 9'(rly), 9'b0001);
    tick(1);
    min11 = 1'b0;
    tick(1);
    check("s3_hold", 9'(rly), 9'b0001);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("s3_dead_rly", 9'(rly), 9'h0);
      check("s3_dead_flag", 9'(dead), 9'b01);
    end
    tick(1);
    check("s3_idle_dead", 9'(dead), 9'h0);
    tick(2);
    check("s3_idle_rly", 9'(rly), 9'h0);
    check("s3_idle_dead2", 9'(dead), 9'h0);

    // Illegal command on channel 1.
    min12 = 1'b1;
    min22 = 1'b1;
    tick(1);
    check("ill_fault_lat", 9'(fault), 9'h0);
    tick(1);
    check("ill_fault_set", 9'(fault), 9'b10);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("ill_rly", 9'(rly), 9'h0);
    end
    min12 = 1'b0;
    min22 = 1'b0;
    tick(3);
    check("fault_sticky", 9'(fault), 9'b10);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_clr", 9'(fault), 9'h0);

    // Set wins over clear in the same cycle.
    min12     = 1'b1;
    min22     = 1'b1;
    fault_clr = 1'b1;
    tick(2);
    check("fault_set_wins", 9'(fault), 9'b10);
    min12     = 1'b0;
    min22     = 1'b0;
    fault_clr = 1'b0;
    tick(1);
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("fault_clr2", 9'(fault), 9'h0);

    // Channel 1 forward mapping.
    min12 = 1'b1;
    tick(2);
    check("ch1_fwd", 9'(rly), 9'b0100);
    min12 = 1'b0;
    tick(6);
    check("ch1_idle", 9'(rly), 9'h0);
    check("ch1_idle_dead", 9'(dead), 9'h0);

    // Enable drop while REV on channel 0.
    min21 = 1'b1;
    tick(2);
    check("en_rev", 9'(rly), 9'b0010);
    enable = 1'b0;
    tick(1);
    check("en_lat", 9'(rly), 9'b0010);
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("en_dead_rly", 9'(rly), 9'h0);
      check("en_dead_flag", 9'(dead), 9'b01);
    end
    tick(1);
    check("en_idle_rly", 9'(rly), 9'h0);
    check("en_idle_dead", 9'(dead), 9'h0);
    enable = 1'b1;
    tick(2);
    check("en_resume", 9'(rly), 9'b0010);

    // Mid-operation reset: immediate drop, no dead time afterwards.
    rst_n = 1'b0;
    #1;
    check("async_rst_rly", 9'(rly), 9'h0);
    check("async_rst_dead", 9'(dead), 9'h0);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    check("post_rst_lat", 9'(rly), 9'h0);
    tick(1);
    check("post_rst_rev", 9'(rly), 9'b0010);
    check("post_rst_dead", 9'(dead), 9'h0);

`ifdef MOTOR_PWM_EN
    begin
      int highs;
      min21 = 1'b0;
      tick(8);
      duty  = 8'd64;
      min11 = 1'b1;
      tick(3);
      highs = 0;
      for (int i = 0; i < 256; i++) begin
        tick(1);
        if (rly11) highs++;
      end
      check("pwm_duty64", 9'(highs), 9'd64);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
